// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, ALU op codes, writeback selects
// and the decoded control bundle carried through the D/E pipeline register.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD     = 3'b000,
        ALU_SUB     = 3'b001,
        ALU_AND     = 3'b010,
        ALU_OR      = 3'b011,
        ALU_SLL     = 3'b100,
        ALU_SLT     = 3'b101,
        ALU_SRL_SRA = 3'b110,
        ALU_XOR     = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // All-zero encoding of this bundle is a bubble: no writeback, no store, no redirect.
    typedef struct packed {
        logic       valid;
        logic [2:0] alu_control;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [1:0] result_src;
        logic [2:0] funct3;
        logic       pred_taken;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset, clear (bubble) and enable (hold).
// Priority on each edge: reset > clear > enable.
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: non-blocking assignment so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// Decode/execute pipeline register with hazard stall (hold) and flush (bubble).
// Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_reg
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pcplus4_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic [2:0]      alu_control_d,
    input  logic            alu_src_d,
    input  logic            reg_write_d,
    input  logic            mem_write_d,
    input  logic            jump_d,
    input  logic            branch_d,
    input  logic [1:0]      result_src_d,
    input  logic [2:0]      funct3_d,
    input  logic            pred_taken_d,
    output logic            valid_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pcplus4_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic [2:0]      alu_control_e,
    output logic            alu_src_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic [1:0]      result_src_e,
    output logic [2:0]      funct3_e,
    output logic            pred_taken_e
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int DATA_W = 5 * XLEN + 15;

    ctrl_t             w_ctrl_d;
    ctrl_t             w_ctrl_e;
    logic [DATA_W-1:0] w_data_d;
    logic [DATA_W-1:0] w_data_e;
    logic              w_load_en;

    // Flush outranks stall inside pipe_reg, so a squash always lands even mid-hold.
    assign w_load_en = ~stall_e;

    always_comb begin
        w_ctrl_d             = '0;
        w_ctrl_d.valid       = valid_d;
        w_ctrl_d.alu_control = alu_control_d;
        w_ctrl_d.alu_src     = alu_src_d;
        w_ctrl_d.reg_write   = reg_write_d;
        w_ctrl_d.mem_write   = mem_write_d;
        w_ctrl_d.jump        = jump_d;
        w_ctrl_d.branch      = branch_d;
        w_ctrl_d.result_src  = result_src_d;
        w_ctrl_d.funct3      = funct3_d;
        w_ctrl_d.pred_taken  = pred_taken_d;
    end

    assign w_data_d = {pc_d, pcplus4_d, rd1_d, rd2_d, imm_ext_d, rs1_d, rs2_d, rd_d};

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_load_en),
        .i_clr (flush_e),
        .i_d   (w_ctrl_d),
        .o_q   (w_ctrl_e)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_load_en),
        .i_clr (flush_e),
        .i_d   (w_data_d),
        .o_q   (w_data_e)
    );

    assign valid_e       = w_ctrl_e.valid;
    assign alu_control_e = w_ctrl_e.alu_control;
    assign alu_src_e     = w_ctrl_e.alu_src;
    assign reg_write_e   = w_ctrl_e.reg_write;
    assign mem_write_e   = w_ctrl_e.mem_write;
    assign jump_e        = w_ctrl_e.jump;
    assign branch_e      = w_ctrl_e.branch;
    assign result_src_e  = w_ctrl_e.result_src;
    assign funct3_e      = w_ctrl_e.funct3;
    assign pred_taken_e  = w_ctrl_e.pred_taken;

    assign {pc_e, pcplus4_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e} = w_data_e;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Counts follow the register's own priority; both wrap silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else if (flush_e) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end else if (stall_e) begin
            r_stall_cnt  <= r_stall_cnt + 1'b1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: expected slots are queued as stimulus is applied
// and compared after each clock edge; counters are checked when ID_EX_PERF_CNT_EN is set.
module tb_id_ex_reg;
    import core_pkg::*;

    localparam int XW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [XW-1:0] pc;
        logic [XW-1:0] pcplus4;
        logic [XW-1:0] rd1;
        logic [XW-1:0] rd2;
        logic [XW-1:0] imm;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        ctrl_t         ctrl;
    } slot_t;

    typedef struct packed {
        slot_t         s;
        logic [CW-1:0] bub;
        logic [CW-1:0] stl;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, stall_e, flush_e;
    slot_t         din, obs, model;
    logic [CW-1:0] m_bub, m_stl;
    exp_t          sb[$];
    int            n_vec = 0;
    int            n_err = 0;

    logic [CW-1:0] bubble_cnt, stall_cnt;

    id_ex_reg #(.XLEN(XW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_e       (stall_e),
        .flush_e       (flush_e),
        .valid_d       (din.ctrl.valid),
        .pc_d          (din.pc),
        .pcplus4_d     (din.pcplus4),
        .rd1_d         (din.rd1),
        .rd2_d         (din.rd2),
        .imm_ext_d     (din.imm),
        .rs1_d         (din.rs1),
        .rs2_d         (din.rs2),
        .rd_d          (din.rd),
        .alu_control_d (din.ctrl.alu_control),
        .alu_src_d     (din.ctrl.alu_src),
        .reg_write_d   (din.ctrl.reg_write),
        .mem_write_d   (din.ctrl.mem_write),
        .jump_d        (din.ctrl.jump),
        .branch_d      (din.ctrl.branch),
        .result_src_d  (din.ctrl.result_src),
        .funct3_d      (din.ctrl.funct3),
        .pred_taken_d  (din.ctrl.pred_taken),
        .valid_e       (obs.ctrl.valid),
        .pc_e          (obs.pc),
        .pcplus4_e     (obs.pcplus4),
        .rd1_e         (obs.rd1),
        .rd2_e         (obs.rd2),
        .imm_ext_e     (obs.imm),
        .rs1_e         (obs.rs1),
        .rs2_e         (obs.rs2),
        .rd_e          (obs.rd),
        .alu_control_e (obs.ctrl.alu_control),
        .alu_src_e     (obs.ctrl.alu_src),
        .reg_write_e   (obs.ctrl.reg_write),
        .mem_write_e   (obs.ctrl.mem_write),
        .jump_e        (obs.ctrl.jump),
        .branch_e      (obs.ctrl.branch),
        .result_src_e  (obs.ctrl.result_src),
        .funct3_e      (obs.ctrl.funct3),
        .pred_taken_e  (obs.ctrl.pred_taken)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt    (bubble_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

`ifndef ID_EX_PERF_CNT_EN
    assign bubble_cnt = '0;
    assign stall_cnt  = '0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t rand_slot();
        slot_t       r;
        logic [31:0] t;
        r.pc      = $urandom;
        r.pcplus4 = $urandom;
        r.rd1     = $urandom;
        r.rd2     = $urandom;
        r.imm     = $urandom;
        t         = $urandom;
        r.rs1     = t[4:0];
        r.rs2     = t[9:5];
        r.rd      = t[14:10];
        t         = $urandom;
        r.ctrl    = t[CTRL_W-1:0];
        return r;
    endfunction

    // Apply one cycle of stimulus, queue the expected outcome, compare after the edge.
    task automatic step(input logic rst, input logic fl, input logic st, input slot_t v);
        exp_t e;
        reset   = rst;
        flush_e = fl;
        stall_e = st;
        din     = v;
        if (rst) begin
            model = '0;
            m_bub = '0;
            m_stl = '0;
        end else if (fl) begin
            model = '0;
            m_bub = m_bub + 1'b1;
        end else if (st) begin
            m_stl = m_stl + 1'b1;
        end else begin
            model = v;
        end
        sb.push_back('{s: model, bub: m_bub, stl: m_stl});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc_e",      64'(obs.pc),      64'(e.s.pc));
        check("pcplus4_e", 64'(obs.pcplus4), 64'(e.s.pcplus4));
        check("rd1_e",     64'(obs.rd1),     64'(e.s.rd1));
        check("rd2_e",     64'(obs.rd2),     64'(e.s.rd2));
        check("imm_e",     64'(obs.imm),     64'(e.s.imm));
        check("regidx_e",  64'({obs.rs1, obs.rs2, obs.rd}), 64'({e.s.rs1, e.s.rs2, e.s.rd}));
        check("ctrl_e",    64'(obs.ctrl),    64'(e.s.ctrl));
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
        check("stall_cnt",  64'(stall_cnt),  64'(e.stl));
`endif
    endtask

    initial begin
        slot_t v;
        reset   = 1'b1;
        flush_e = 1'b0;
        stall_e = 1'b0;
        din     = '0;
        model   = '0;
        m_bub   = '0;
        m_stl   = '0;

        // Reset with non-zero inputs for two cycles.
        v = rand_slot();
        v.ctrl.alu_control = ALU_XOR;
        v.pc = 32'hFFFF_FFF0;
        step(1'b1, 1'b0, 1'b0, v);
        step(1'b1, 1'b1, 1'b1, v);
        check("rst_alu_add", 64'(obs.ctrl.alu_control), 64'(ALU_ADD));
        check("rst_valid",   64'(obs.ctrl.valid), 64'd0);

        // Plain load.
        v = rand_slot();
        v.pc = 32'h0000_0040;
        v.rd1 = 32'h1234_5678;
        v.ctrl.alu_control = ALU_SUB;
        v.ctrl.reg_write = 1'b1;
        step(1'b0, 1'b0, 1'b0, v);
        check("load_rd1", 64'(obs.rd1), 64'h1234_5678);

        // Stall three cycles, then release.
        v.pc = 32'h0000_0044;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, v);
        check("stall_hold_pc", 64'(obs.pc), 64'h40);
`ifdef ID_EX_PERF_CNT_EN
        check("stall_cnt_3", 64'(stall_cnt), 64'd3);
`endif
        step(1'b0, 1'b0, 1'b0, v);
        check("stall_release_pc", 64'(obs.pc), 64'h44);

        // Flush with live controls.
        v = rand_slot();
        v.ctrl.reg_write = 1'b1;
        v.ctrl.mem_write = 1'b1;
        v.ctrl.branch = 1'b1;
        v.ctrl.valid = 1'b1;
        step(1'b0, 1'b1, 1'b0, v);
        check("flush_ctrl", 64'(obs.ctrl), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_cnt_1", 64'(bubble_cnt), 64'd1);
`endif

        // Flush and stall together: flush wins.
        v = rand_slot();
        v.pc = 32'h0000_0080;
        v.ctrl.reg_write = 1'b1;
        step(1'b0, 1'b0, 1'b0, v);
        step(1'b0, 1'b1, 1'b1, rand_slot());
        check("flush_stall_pc", 64'(obs.pc), 64'd0);
        check("flush_stall_rw", 64'(obs.ctrl.reg_write), 64'd0);

        // Counter wrap: 17 flushes from reset on a 4-bit counter.
        step(1'b1, 1'b0, 1'b0, rand_slot());
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, rand_slot());
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_wrap", 64'(bubble_cnt), 64'd1);
`endif

        // Reset mid-stream while stall and flush are active, then first load.
        step(1'b0, 1'b0, 1'b0, rand_slot());
        step(1'b1, 1'b1, 1'b1, rand_slot());
        step(1'b0, 1'b0, 1'b0, rand_slot());

        // Random traffic with occasional hazards and resets.
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, rand_slot());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between decode (D) and execute (E) in the 5-stage RV32I core. It captures the decoded control bundle (ALU control, operand select, writeback/memory/branch controls, prediction bit) and the data bundle (PCs, register operands, immediate, register indices) once per cycle. It supports hazard-unit stall (hold) and flush (bubble insertion on load-use or branch mispredict). Outputs feed the E-stage forwarding muxes, ALU, branch resolver and EX/MEM register.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, performance counter width (used only with the perf feature)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_e  in  1  hold current contents
- flush_e  in  1  load a bubble
- valid_d  in  1  D-stage holds a real instruction
- pc_d, pcplus4_d  in  XLEN  instruction PC, PC+4
- rd1_d, rd2_d  in  XLEN  register-file read data
- imm_ext_d  in  XLEN  sign-extended immediate
- rs1_d, rs2_d, rd_d  in  5  register indices
- alu_control_d  in  3  ALU op code
- alu_src_d  in  1  1 = immediate as operand B
- reg_write_d, mem_write_d, jump_d, branch_d  in  1  control strobes
- result_src_d  in  2  writeback select (00 ALU, 01 mem, 10 PC+4)
- funct3_d  in  3  branch condition select
- pred_taken_d  in  1  branch-predictor guess
- Matching _e outputs for every _d input above, same widths
- bubble_cnt, stall_cnt  out  CNT_W  perf counters (ID_EX_PERF_CNT_EN only)

## Operation
- Priority each edge: reset > flush_e > stall_e > load.
- reset: every output register cleared to 0 (alu_control_e = 000 = add, result_src_e = 00, valid_e = 0); counters cleared.
- flush_e: valid_e, reg_write_e, mem_write_e, jump_e, branch_e, pred_taken_e = 0; all other fields = 0. A bubble must never write the register file or memory or redirect the PC.
- stall_e (no flush): all outputs hold; inputs ignored.
- load: every _e output takes its _d input.
- flush_e and stall_e both high: flush wins (mispredict squash overrides load-use hold).
- valid_d = 0 on load: fields loaded as presented; the D-stage guarantees controls are already zero for invalid slots; the block does not re-mask.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: value at D on edge N visible at E outputs after edge N.
- stall held K cycles: outputs unchanged for K edges, load resumes on the first edge with stall_e = 0.
- reset asserted mid-stream: outputs zero after that edge regardless of stall/flush; first load on the first edge after reset deasserts.
- Counters: bubble_cnt +1 on each edge where flush_e = 1 and reset = 0; stall_cnt +1 on each edge where stall_e = 1, flush_e = 0, reset = 0. Both wrap from 2^CNT_W−1 to 0 silently.

## Configuration
- ID_EX_PERF_CNT_EN defined: bubble_cnt and stall_cnt ports and counters present as above.
- Undefined: ports removed, no counter logic; all other behaviour identical.

## Structure
- Shared package core_pkg: ALU control constants (ADD 000, SUB 001, AND 010, OR 011, SLL 100, SLT 101, SRL/SRA 110, XOR 111), result_src constants (RES_ALU 00, RES_MEM 01, RES_PC4 10), XLEN default.
- One sub-module: pipe_reg, parameterised width with en/clr/reset and reset value 0. Instantiate once for the control bundle and once for the data bundle.
- Counters live in the top module under the macro.

## Test plan
- Reset: drive all _d inputs non-zero, reset = 1 for 2 cycles -> all _e = 0, alu_control_e = 000, counters = 0.
- Load: pc_d = 0x0000_0040, rd1_d = 0x1234_5678, alu_control_d = 001, reg_write_d = 1 -> same values at _e after one edge.
- Stall: load pc = 0x40, then stall_e = 1 for 3 cycles with pc_d = 0x44 -> pc_e stays 0x40 for 3 cycles, becomes 0x44 one edge after release; stall_cnt = 3.
- Flush: reg_write_d = mem_write_d = branch_d = 1, flush_e = 1 -> all controls 0, valid_e = 0; bubble_cnt = 1.
- Flush + stall together: pc_e = 0x80 held, assert both -> pc_e = 0, reg_write_e = 0; bubble_cnt +1, stall_cnt unchanged.
- Wrap (CNT_W = 4): 17 consecutive flushes -> bubble_cnt = 1.
